// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: sync, visible, line/frame pulses and linear pixel index.
// Define VGA_TIMING_CLKDIV_EN when clk runs at twice the pixel rate (pixel tick every 2nd clk).
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic        line,
    output logic        frame,
    output logic [19:0] pixel,
    output logic [9:0]  x,
    output logic [9:0]  y
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [19:0] pix_cnt;
    logic        tick;

`ifdef VGA_TIMING_CLKDIV_EN
    logic tog;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tog <= 1'b0;
        end else if (!enable) begin
            tog <= 1'b0;
        end else begin
            tog <= ~tog;
        end
    end

    assign tick = tog;
`else
    assign tick = 1'b1;
`endif

    // Stage 0: decode flags from the current (pre-increment) counters
    logic vis_p0;
    logic hs_p0;
    logic vs_p0;
    logic line_p0;
    logic frame_p0;

    assign vis_p0   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign hs_p0    = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_p0    = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign line_p0  = (h_cnt == H_VIS_END);
    assign frame_p0 = (h_cnt == 10'd0) && (v_cnt == V_VIS_END);

    // Stage 1: counters advance and decoded flags are registered to the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            pix_cnt <= '0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            visible <= 1'b0;
            line    <= 1'b0;
            frame   <= 1'b0;
            pixel   <= '0;
            x       <= '0;
            y       <= '0;
        end else if (!enable) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            pix_cnt <= '0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            visible <= 1'b0;
            line    <= 1'b0;
            frame   <= 1'b0;
            pixel   <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            // Pulses last one clk even when levels are held across a divided pixel period
            line  <= 1'b0;
            frame <= 1'b0;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end

                if (frame_p0) begin
                    pix_cnt <= '0;
                end else if (vis_p0) begin
                    pix_cnt <= pix_cnt + 20'd1;
                end

                hsync   <= hs_p0;
                vsync   <= vs_p0;
                visible <= vis_p0;
                line    <= line_p0;
                frame   <= frame_p0;
                pixel   <= pix_cnt;
                x       <= h_cnt;
                y       <= v_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance and a default-geometry instance share clk/rst/enable.
// Expected outputs come from a closed-form raster model indexed by the number of pixel ticks since restart.
module tb_vga_timing_gen;

    localparam bit SP  = 1'b0;
    localparam int SHV = 16;
    localparam int SHF = 2;
    localparam int SHS = 4;
    localparam int SHB = 3;
    localparam int SVV = 8;
    localparam int SVF = 2;
    localparam int SVS = 2;
    localparam int SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
`ifdef VGA_TIMING_CLKDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    logic        s_hs, s_vs, s_vis, s_line, s_frame;
    logic [19:0] s_pixel;
    logic [9:0]  s_x, s_y;
    logic        d_hs, d_vs, d_vis, d_line, d_frame;
    logic [19:0] d_pixel;
    logic [9:0]  d_x, d_y;

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .SYNC_POL(SP)
    ) u_small (
        .clk(clk), .rst(rst), .enable(enable),
        .hsync(s_hs), .vsync(s_vs), .visible(s_vis), .line(s_line), .frame(s_frame),
        .pixel(s_pixel), .x(s_x), .y(s_y)
    );

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst), .enable(enable),
        .hsync(d_hs), .vsync(d_vs), .visible(d_vis), .line(d_line), .frame(d_frame),
        .pixel(d_pixel), .x(d_x), .y(d_y)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vis;
        logic        line;
        logic        frame;
        logic [19:0] pixel;
        logic [9:0]  x;
        logic [9:0]  y;
    } out_t;

    typedef struct {
        int   ticks;
        out_t exp;
    } vec_t;

    out_t act_s, act_d, exp_s, exp_d;
    assign act_s = {s_hs, s_vs, s_vis, s_line, s_frame, s_pixel, s_x, s_y};
    assign act_d = {d_hs, d_vs, d_vis, d_line, d_frame, d_pixel, d_x, d_y};

    int checks;
    int errors;
    int cyc;
    int n;
    int en_clks;
    vec_t vt[14];

    function automatic out_t idle_out();
        out_t o = '0;
        o.hs = !SP;
        o.vs = !SP;
        return o;
    endfunction

    // Raster position n ticks after restart, expressed directly from the timing rules
    function automatic out_t ref_pos(input int pos, input int hv, input int hf, input int hs,
                                     input int hb, input int vv, input int vf, input int vs,
                                     input int vb);
        int ht = hv + hf + hs + hb;
        int vtot = vv + vf + vs + vb;
        int h = pos % ht;
        int v = (pos / ht) % vtot;
        out_t o;
        o.x     = 10'(h);
        o.y     = 10'(v);
        o.vis   = (h < hv) && (v < vv);
        o.hs    = (h >= hv + hf && h < hv + hf + hs) ? SP : !SP;
        o.vs    = (v >= vv + vf && v < vv + vf + vs) ? SP : !SP;
        o.line  = (h == hv);
        o.frame = (h == 0) && (v == vv);
        if (v < vv)
            o.pixel = 20'(v * hv + ((h < hv) ? h : hv));
        else if (v == vv && h == 0)
            o.pixel = 20'(hv * vv);
        else
            o.pixel = 20'd0;
        return o;
    endfunction

    function automatic vec_t mk(input int t, input logic vis, input logic hs, input logic vs,
                                input logic ln, input logic fr, input int pix, input int xx,
                                input int yy);
        vec_t r;
        r.ticks = t;
        r.exp   = {hs, vs, vis, ln, fr, 20'(pix), 10'(xx), 10'(yy)};
        return r;
    endfunction

    task automatic check_o(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst || !enable) begin
            exp_s   = idle_out();
            exp_d   = idle_out();
            n       = 0;
            en_clks = 0;
        end else begin
            en_clks++;
            if (en_clks % DIV == 0) begin
                exp_s = ref_pos(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
                exp_d = ref_pos(n, 640, 16, 96, 48, 480, 10, 2, 33);
                n++;
            end else begin
                exp_s.line  = 1'b0;
                exp_s.frame = 1'b0;
                exp_d.line  = 1'b0;
                exp_d.frame = 1'b0;
            end
        end
        #1;
        check_o("small_cycle", act_s, exp_s);
        check_o("dflt_cycle", act_d, exp_d);
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    initial begin
        int bound;
        int nf, ft0, ft1, wide, vis_cnt, line_cnt, hs_lo, vs_lo, first_pix, last_pix, ovl, badx;
        logic prev_frame;
        int found;

        checks  = 0;
        errors  = 0;
        cyc     = 0;
        n       = 0;
        en_clks = 0;
        exp_s   = idle_out();
        exp_d   = idle_out();

        vt[0]  = mk(1,   1, 1, 1, 0, 0, 0,   0,  0);
        vt[1]  = mk(16,  1, 1, 1, 0, 0, 15,  15, 0);
        vt[2]  = mk(17,  0, 1, 1, 1, 0, 16,  16, 0);
        vt[3]  = mk(19,  0, 0, 1, 0, 0, 16,  18, 0);
        vt[4]  = mk(22,  0, 0, 1, 0, 0, 16,  21, 0);
        vt[5]  = mk(23,  0, 1, 1, 0, 0, 16,  22, 0);
        vt[6]  = mk(26,  1, 1, 1, 0, 0, 16,  0,  1);
        vt[7]  = mk(191, 1, 1, 1, 0, 0, 127, 15, 7);
        vt[8]  = mk(201, 0, 1, 1, 0, 1, 128, 0,  8);
        vt[9]  = mk(202, 0, 1, 1, 0, 0, 0,   1,  8);
        vt[10] = mk(217, 0, 1, 1, 1, 0, 0,   16, 8);
        vt[11] = mk(251, 0, 1, 0, 0, 0, 0,   0,  10);
        vt[12] = mk(301, 0, 1, 1, 0, 0, 0,   0,  12);
        vt[13] = mk(376, 1, 1, 1, 0, 0, 0,   0,  0);

        // Reset state, including asynchronous assertion before any clock edge
        rst    = 1'b1;
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_o("reset_async_state", act_s, idle_out());
        step();
        step();
        check_o("reset_state_dflt", act_d, idle_out());
        rst    = 1'b1;
        enable = 1'b1;
        repeat (DIV) step();
        check_i("first_visible_after_reset", int'(s_vis), 1);
        check_i("first_pixel_after_reset", int'(s_pixel), 0);

        // Table of landmark raster positions on the reduced geometry
        restart();
        for (int i = 0; i < 14; i++) begin
            bound = 0;
            while (n < vt[i].ticks && bound < 1000 * DIV) begin
                step();
                bound++;
            end
            check_o($sformatf("vec%0d_t%0d", i, vt[i].ticks), act_s, vt[i].exp);
        end

        // Whole-frame statistics between two frame pulses
        restart();
        nf = 0; ft0 = 0; ft1 = 0; wide = 0; vis_cnt = 0; line_cnt = 0; hs_lo = 0; vs_lo = 0;
        first_pix = -1; last_pix = -1; ovl = 0; badx = 0; prev_frame = 1'b0;
        for (int k = 0; k < 3 * SHT * SVT * DIV + 5; k++) begin
            step();
            if (s_frame) begin
                if (prev_frame) wide++;
                if (nf == 0) ft0 = cyc;
                else if (nf == 1) ft1 = cyc;
                nf++;
            end
            if (nf == 1) begin
                if (s_vis) begin
                    vis_cnt++;
                    if (first_pix < 0) first_pix = int'(s_pixel);
                    last_pix = int'(s_pixel);
                end
                if (s_line) line_cnt++;
                if (!s_hs) hs_lo++;
                if (!s_vs) vs_lo++;
            end
            if (s_line && s_vis) ovl++;
            if (s_line && s_x != 10'(SHV)) badx++;
            prev_frame = s_frame;
        end
        check_i("frame_pulses_seen", int'(nf >= 2), 1);
        check_i("frame_period", ft1 - ft0, SHT * SVT * DIV);
        check_i("frame_width", wide, 0);
        check_i("visible_clks_per_frame", vis_cnt, SHV * SVV * DIV);
        check_i("line_pulses_per_frame", line_cnt, SVT);
        check_i("hsync_low_clks_per_frame", hs_lo, SHS * SVT * DIV);
        check_i("vsync_low_clks_per_frame", vs_lo, SVS * SHT * DIV);
        check_i("first_pixel_index", first_pix, 0);
        check_i("last_pixel_index", last_pix, SHV * SVV - 1);
        check_i("line_visible_overlap", ovl, 0);
        check_i("line_x_position", badx, 0);

        // Drop enable mid-frame, then measure the delay to the next frame pulse
        bound = 0;
        while (!(s_y == 10'd4 && s_x == 10'd7) && bound < 2 * SHT * SVT * DIV) begin
            step();
            bound++;
        end
        check_i("enable_drop_position_reached", int'(s_y == 10'd4 && s_x == 10'd7), 1);
        enable = 1'b0;
        repeat (5) step();
        check_o("enable_low_idle", act_s, idle_out());
        enable = 1'b1;
        bound = 0;
        found = 0;
        while (found == 0 && bound < 2 * SHT * SVT * DIV) begin
            step();
            bound++;
            if (s_frame) found = 1;
        end
        check_i("reenable_frame_delay", bound, DIV * (SVV * SHT + 1));

        // Asynchronous reset while hsync is asserted
        bound = 0;
        while (s_hs != SP && bound < 2 * SHT * DIV) begin
            step();
            bound++;
        end
        check_i("hsync_asserted_before_reset", int'(s_hs), int'(SP));
        #2 rst = 1'b0;
        #1;
        check_o("async_reset_midline", act_s, idle_out());
        step();
        rst = 1'b1;

        // Default geometry: two full lines
        restart();
        hs_lo = 0; vis_cnt = 0; line_cnt = 0; badx = 0;
        for (int k = 0; k < 2 * 800 * DIV; k++) begin
            step();
            if (!d_hs) hs_lo++;
            if (d_vis) vis_cnt++;
            if (d_line) begin
                line_cnt++;
                if (d_x != 10'd640) badx++;
            end
        end
        check_i("dflt_hsync_low_clks", hs_lo, 2 * 96 * DIV);
        check_i("dflt_visible_clks", vis_cnt, 2 * 640 * DIV);
        check_i("dflt_line_pulses", line_cnt, 2);
        check_i("dflt_line_x", badx, 0);

        // Randomized enable drops and reset pulses, checked every cycle against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 999));
            rst    = (r == 0) ? 1'b0 : 1'b1;
            enable = (r >= 1 && r < 4) ? 1'b0 : 1'b1;
            step();
        end
        rst    = 1'b1;
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
